o_ddr_tx: RTL
=============

O_DDR_TX -- requirements
Module: o_ddr_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 2-bit FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b0, level driven on Q when not transmitting.
REQ-003 SHALL have port C  input  1  clock; one clock only.
REQ-004 SHALL have port R  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port D  input  2  data word; D[1] is sent in the high phase of C, D[0] in the low phase.
REQ-006 SHALL have port D_VALID  input  1  word on D is offered.
REQ-007 SHALL have port D_READY  output  1  FIFO can accept a word.
REQ-008 SHALL have port E  input  1  active-high transmit enable, sampled on posedge C.
REQ-009 SHALL have port Q  output  1  DDR serial output (to output buffer).
REQ-010 SHALL have port OE  output  1  active-high output enable for the tri-state buffer.
REQ-011 SHALL have port UNDERRUN  output  1  one-cycle pulse on underrun.
REQ-012 SHALL have port LEVEL  output  clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-013 SHALL write D into the FIFO on posedge C when D_VALID && D_READY; D_READY = (LEVEL != DEPTH).
REQ-014 SHALL not bypass the FIFO: a word written at posedge k is poppable no earlier than posedge k+1.
REQ-015 SHALL allow a simultaneous push and pop when not full; LEVEL is then unchanged; push when full is ignored.
REQ-016 SHALL implement states IDLE, ACTIVE, PAUSE, evaluated on posedge C.
REQ-017 IDLE: E && !empty -> ACTIVE with pop; otherwise stay. Q = IDLE_LEVEL, OE = 0.
REQ-018 ACTIVE: E && !empty -> pop and stay; E && empty -> IDLE with UNDERRUN pulse; !E -> PAUSE.
REQ-019 PAUSE: E && !empty -> ACTIVE with pop; E && empty -> IDLE, no UNDERRUN pulse; !E -> stay, repeating the last word with OE = 1.
REQ-020 On a pop at posedge k, the word SHALL be loaded into out_pos/out_neg registers. Q = out_pos from posedge k to negedge k. Q = out_neg, recaptured on negedge C, from negedge k to posedge k+1.
REQ-021 Q SHALL be glitch-free: selection is by registered values only; C is not used combinationally as a data mux select.
REQ-022 OE SHALL change only on posedge C, in the same cycle in which Q first or last carries word data.
REQ-023 LEVEL SHALL wrap the FIFO pointers modulo DEPTH, with one extra bit to distinguish full from empty.

Reset
REQ-024 R low SHALL immediately clear the FIFO (LEVEL = 0) and set state IDLE, Q = IDLE_LEVEL, OE = 0, UNDERRUN = 0.
REQ-025 D_READY SHALL be 0 while R is low and 1 at the first posedge C after R rises.
REQ-026 Reset mid-transmission SHALL discard all buffered words; no partial word is emitted after release.

Configuration
REQ-027 With O_DDR_TX_UNDERRUN_CNT_EN defined, the block SHALL add output UNDERRUN_CNT [7:0], which increments on each UNDERRUN pulse, saturates at 255, and is cleared by R.
REQ-028 Without the macro, the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package o_ddr_tx_pkg SHALL hold the state enum type (IDLE, ACTIVE, PAUSE) and the default DEPTH and IDLE_LEVEL constants.
REQ-030 The FIFO SHALL be the sub-module o_ddr_tx_fifo (push, pop, level, full, empty); the FSM and DDR output registers stay in o_ddr_tx.

Verification
REQ-031 Reset, E=1, no writes -> Q=IDLE_LEVEL, OE=0, LEVEL=0, UNDERRUN never pulses.
REQ-032 Push 2'b10, 2'b01 on consecutive cycles, E=1 -> Q sequence per half-cycle 1,0,0,1, then IDLE; OE high exactly 2 cycles; one UNDERRUN pulse.
REQ-033 Push 5 words with E=0 -> D_READY falls after the 4th; the 5th word is dropped; LEVEL=4.
REQ-034 Stream 2'b11, drop E for 3 cycles mid-stream -> PAUSE; Q repeats the last word with OE=1; stream resumes without loss on E=1.
REQ-035 Assert R low mid-stream with LEVEL=3 -> Q=IDLE_LEVEL and OE=0 immediately; LEVEL=0; after release, no stale word is sent.
REQ-036 With macro defined, force 300 underruns -> UNDERRUN_CNT=255.

Source files
------------

// File: rtl/o_ddr_tx_pkg.sv
// Shared types and defaults for the DDR serial transmitter.
package o_ddr_tx_pkg;

  localparam int unsigned DEFAULT_DEPTH      = 4;
  localparam logic        DEFAULT_IDLE_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSE  = 2'd2
  } state_e;

  // hi is driven while C is high, lo while C is low
  typedef struct packed {
    logic hi;
    logic lo;
  } ddr_word_t;

endpackage

// File: rtl/o_ddr_tx_fifo.sv
// Word FIFO for the DDR transmitter; pointers carry one extra wrap bit.
module o_ddr_tx_fifo
  import o_ddr_tx_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  ddr_word_t                      wdata,
  input  logic                           pop,
  output ddr_word_t                      rdata,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  ddr_word_t     mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign level   = LW'(wptr - rptr);
  assign full    = (level == LW'(DEPTH));
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/o_ddr_tx.sv
// DDR serial transmitter: FIFO-fed, IDLE/ACTIVE/PAUSE control, glitch-free DDR output.
// Optional O_DDR_TX_UNDERRUN_CNT_EN adds a saturating UNDERRUN_CNT output.
module o_ddr_tx
  import o_ddr_tx_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter logic        IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic                        C,
  input  logic                        R,
  input  logic [1:0]                  D,
  input  logic                        D_VALID,
  output logic                        D_READY,
  input  logic                        E,
  output logic                        Q,
  output logic                        OE,
  output logic                        UNDERRUN,
  output logic [$clog2(DEPTH+1)-1:0]  LEVEL
`ifdef O_DDR_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]                  UNDERRUN_CNT
`endif
);

  state_e    state;
  state_e    state_nxt;
  ddr_word_t rdata;
  ddr_word_t word_nxt;
  ddr_word_t idle_word;
  logic      full;
  logic      empty;
  logic      pop;
  logic      push;
  logic      rdy_q;
  logic      underrun_nxt;
  logic      out_pos;
  logic      out_neg;
  logic      pos_enc;
  logic      neg_enc;

  assign idle_word = '{hi: IDLE_LEVEL, lo: IDLE_LEVEL};
  assign D_READY   = rdy_q && !full;
  assign push      = D_VALID && D_READY;

  o_ddr_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (C),
    .rst_n (R),
    .push  (push),
    .wdata (ddr_word_t'(D)),
    .pop   (pop),
    .rdata (rdata),
    .level (LEVEL),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    underrun_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (E && !empty) begin
          state_nxt = ACTIVE;
          pop       = 1'b1;
        end
      end
      ACTIVE: begin
        if (!E) begin
          state_nxt = PAUSE;
        end else if (!empty) begin
          pop = 1'b1;
        end else begin
          state_nxt    = IDLE;
          underrun_nxt = 1'b1;
        end
      end
      PAUSE: begin
        if (E && !empty) begin
          state_nxt = ACTIVE;
          pop       = 1'b1;
        end else if (E) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // PAUSE keeps replaying the word already held in out_pos/out_neg
    word_nxt = idle_word;
    if (pop) begin
      word_nxt = rdata;
    end else if (state_nxt == PAUSE) begin
      word_nxt = '{hi: out_pos, lo: out_neg};
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state    <= IDLE;
      rdy_q    <= 1'b0;
      OE       <= 1'b0;
      UNDERRUN <= 1'b0;
      out_pos  <= IDLE_LEVEL;
      out_neg  <= IDLE_LEVEL;
      pos_enc  <= IDLE_LEVEL;
    end else begin
      state    <= state_nxt;
      rdy_q    <= 1'b1;
      OE       <= (state_nxt != IDLE);
      UNDERRUN <= underrun_nxt;
      out_pos  <= word_nxt.hi;
      out_neg  <= word_nxt.lo;
      pos_enc  <= word_nxt.hi ^ neg_enc;
    end
  end

  // XOR-encoded edge pair: each edge flips exactly one flop, so Q never needs C as a mux select
  always_ff @(negedge C or negedge R) begin
    if (!R) begin
      neg_enc <= 1'b0;
    end else begin
      neg_enc <= out_neg ^ pos_enc;
    end
  end

  assign Q = pos_enc ^ neg_enc;

`ifdef O_DDR_TX_UNDERRUN_CNT_EN
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      UNDERRUN_CNT <= 8'd0;
    end else if (underrun_nxt && (UNDERRUN_CNT != 8'hFF)) begin
      UNDERRUN_CNT <= UNDERRUN_CNT + 8'd1;
    end
  end
`endif

endmodule
